usart_lite: RTL and testbench

Synthesizable asynchronous-only USART on the AS2650 I/O bus, programmed with the 8251-style sequence the firmware already uses: a mode word, then a command word, then data. It sits directly downstream of the CPU's I/O strobes (IOC = control port, IOD = data port) and serialises transmitted bytes onto `txd`. It also deserialises `rxd` into a holding register that the CPU reads back. It replaces the behavioural UART model in the simulation bench.

---
 rtl/usart_lite.sv | 210 +++++++++++++++++++++
 tb/tb_usart_lite.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usart_lite.sv
// Asynchronous-only 8251-style USART on the AS2650 I/O bus: mode/command sequencer,
// THR-to-txd serialiser and rxd-to-RHR deserialiser with PE/OE/FE status.
module usart_lite #(
    parameter int unsigned BAUD_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       io_c,
    input  logic       io_d,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rxd,
    output logic       txd,
    output logic       txrdy,
    output logic       rxrdy
);

    typedef enum logic {SeqMode, SeqCmd} seq_e;
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} frame_e;

    seq_e        seq_q, seq_d;
    logic [7:0]  mode_q, mode_d;
    logic        txen_q, txen_d, rxe_q, rxe_d;
    logic        pe_q, pe_d, oe_q, oe_d, fe_q, fe_d;
    logic [7:0]  thr_q, thr_d, rhr_q, rhr_d, dout_q, dout_d;
    logic        thr_full_q, thr_full_d, rxrdy_q, rxrdy_d;
    frame_e      tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic        tx_par_q, tx_par_d, tx_stop_q, tx_stop_d, txd_q, txd_d;
    logic        rx_par_q, rx_par_d;
    logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic [31:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

    logic [31:0] bit_len, half_m1;
    logic [7:0]  data_mask, status;
    logic [2:0]  last_bit;
    logic        ctrl_wr, data_wr, ctrl_rd, data_rd, int_rst;
    logic        tx_tick, tx_load, tx_end, rx_centre, tx_empty;

    assign ctrl_wr = wr & io_c;
    assign data_wr = wr & io_d & ~io_c;
    assign ctrl_rd = rd & io_c;
    assign data_rd = rd & io_d & ~io_c;
    assign int_rst = ctrl_wr & (seq_q == SeqCmd) & (din[6] | din[7]);

    // TxEMPTY only reports once the transmitter is enabled, so a freshly reset part reads 0x00.
    assign tx_empty = txen_q & ~thr_full_q & (tx_state_q == StIdle);
    assign status   = {2'b00, fe_q, oe_q, pe_q, tx_empty, rxrdy_q, txen_q & ~thr_full_q};
    assign last_bit = 3'd4 + {1'b0, mode_q[3:2]};

    always_comb begin
        unique case (mode_q[1:0])
            2'b10:   bit_len = BAUD_DIV * 32'd16;
            2'b11:   bit_len = BAUD_DIV * 32'd64;
            default: bit_len = BAUD_DIV;
        endcase
        half_m1 = (bit_len > 32'd1) ? (bit_len >> 1) - 32'd1 : 32'd0;
        unique case (mode_q[3:2])
            2'b00:   data_mask = 8'h1F;
            2'b01:   data_mask = 8'h3F;
            2'b10:   data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
    end

    always_comb begin
        seq_d = seq_q;  mode_d = mode_q;  txen_d = txen_q;  rxe_d = rxe_q;
        pe_d = pe_q;  oe_d = oe_q;  fe_d = fe_q;
        thr_d = thr_q;  thr_full_d = thr_full_q;  rhr_d = rhr_q;  rxrdy_d = rxrdy_q;
        dout_d = dout_q;
        tx_state_d = tx_state_q;  tx_sh_d = tx_sh_q;  tx_bit_d = tx_bit_q;
        tx_par_d = tx_par_q;  tx_stop_d = tx_stop_q;  txd_d = txd_q;
        rx_state_d = rx_state_q;  rx_sh_d = rx_sh_q;  rx_bit_d = rx_bit_q;  rx_par_d = rx_par_q;
        rx_s1_d = rxd;  rx_s2_d = rx_s1_q;  rx_prev_d = rx_s2_q;
        rx_cnt_d = rx_cnt_q + 32'd1;

        tx_tick  = (tx_cnt_q >= bit_len - 32'd1);
        tx_cnt_d = tx_tick ? 32'd0 : tx_cnt_q + 32'd1;
        tx_load  = thr_full_q & txen_q;
        tx_end   = 1'b0;

        if (tx_tick) begin
            unique case (tx_state_q)
                StIdle:  tx_end = 1'b1;
                StStart: begin
                    txd_d = tx_sh_q[0];  tx_sh_d = {1'b0, tx_sh_q[7:1]};
                    tx_bit_d = 3'd0;  tx_state_d = StData;
                end
                StData: begin
                    if (tx_bit_q == last_bit) begin
                        txd_d = mode_q[4] ? tx_par_q : 1'b1;
                        tx_state_d = mode_q[4] ? StParity : StStop;
                        tx_stop_d = mode_q[7];
                    end else begin
                        txd_d = tx_sh_q[0];  tx_sh_d = {1'b0, tx_sh_q[7:1]};
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
                StParity: begin
                    txd_d = 1'b1;  tx_state_d = StStop;  tx_stop_d = mode_q[7];
                end
                default: begin
                    txd_d = 1'b1;
                    if (tx_stop_q) tx_stop_d = 1'b0;
                    else begin
                        tx_state_d = StIdle;  tx_end = 1'b1;
                    end
                end
            endcase
            // Reloading straight out of the stop bit keeps back-to-back frames gapless.
            if (tx_end && tx_load) begin
                tx_sh_d = thr_q & data_mask;  thr_full_d = 1'b0;
                tx_par_d = (^(thr_q & data_mask)) ^ ~mode_q[5];
                txd_d = 1'b0;  tx_state_d = StStart;
            end
        end

        if (ctrl_wr) begin
            if (seq_q == SeqMode) begin
                mode_d = din;  seq_d = SeqCmd;
            end else begin
                txen_d = din[0];  rxe_d = din[2];
                if (din[4]) begin
                    pe_d = 1'b0;  oe_d = 1'b0;  fe_d = 1'b0;
                end
            end
        end else if (data_wr && seq_q == SeqCmd) begin
            thr_d = din;  thr_full_d = 1'b1;
        end

        if (ctrl_rd) dout_d = status;
        else if (data_rd) begin
            dout_d = rhr_q;  rxrdy_d = 1'b0;
        end

        rx_centre = (rx_cnt_q >= bit_len - 32'd1);
        unique case (rx_state_q)
            StIdle: begin
                rx_cnt_d = 32'd0;
                if (rxe_q && rx_prev_q && !rx_s2_q) rx_state_d = StStart;
            end
            StStart: begin
                if (rx_cnt_q >= half_m1) begin
                    rx_cnt_d = 32'd0;  rx_bit_d = 3'd0;  rx_sh_d = 8'h00;
                    rx_state_d = rx_s2_q ? StIdle : StData;
                end
            end
            StData: begin
                if (rx_centre) begin
                    rx_cnt_d = 32'd0;  rx_sh_d[rx_bit_q] = rx_s2_q;
                    if (rx_bit_q == last_bit) rx_state_d = mode_q[4] ? StParity : StStop;
                    else rx_bit_d = rx_bit_q + 3'd1;
                end
            end
            StParity: begin
                if (rx_centre) begin
                    rx_cnt_d = 32'd0;  rx_par_d = rx_s2_q;  rx_state_d = StStop;
                end
            end
            default: begin
                if (rx_centre) begin
                    rhr_d = rx_sh_q;  rxrdy_d = 1'b1;  rx_state_d = StIdle;
                    if (rxrdy_q) oe_d = 1'b1;
                    if (!rx_s2_q) fe_d = 1'b1;
                    if (mode_q[4] && (rx_par_q != ((^rx_sh_q) ^ ~mode_q[5]))) pe_d = 1'b1;
                end
            end
        endcase

        if (int_rst) begin
            seq_d = SeqMode;  mode_d = 8'h00;  txen_d = 1'b0;  rxe_d = 1'b0;
            pe_d = 1'b0;  oe_d = 1'b0;  fe_d = 1'b0;
            thr_d = 8'h00;  thr_full_d = 1'b0;  rhr_d = 8'h00;  rxrdy_d = 1'b0;
            tx_state_d = StIdle;  txd_d = 1'b1;  tx_cnt_d = 32'd0;
            rx_state_d = StIdle;  rx_cnt_d = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q <= SeqMode;  mode_q <= 8'h00;  txen_q <= 1'b0;  rxe_q <= 1'b0;
            pe_q <= 1'b0;  oe_q <= 1'b0;  fe_q <= 1'b0;
            thr_q <= 8'h00;  thr_full_q <= 1'b0;  rhr_q <= 8'h00;  rxrdy_q <= 1'b0;
            dout_q <= 8'h00;
            tx_state_q <= StIdle;  tx_sh_q <= 8'h00;  tx_bit_q <= 3'd0;
            tx_par_q <= 1'b0;  tx_stop_q <= 1'b0;  txd_q <= 1'b1;  tx_cnt_q <= 32'd0;
            rx_state_q <= StIdle;  rx_sh_q <= 8'h00;  rx_bit_q <= 3'd0;  rx_par_q <= 1'b0;
            rx_s1_q <= 1'b1;  rx_s2_q <= 1'b1;  rx_prev_q <= 1'b1;  rx_cnt_q <= 32'd0;
        end else begin
            seq_q <= seq_d;  mode_q <= mode_d;  txen_q <= txen_d;  rxe_q <= rxe_d;
            pe_q <= pe_d;  oe_q <= oe_d;  fe_q <= fe_d;
            thr_q <= thr_d;  thr_full_q <= thr_full_d;  rhr_q <= rhr_d;  rxrdy_q <= rxrdy_d;
            dout_q <= dout_d;
            tx_state_q <= tx_state_d;  tx_sh_q <= tx_sh_d;  tx_bit_q <= tx_bit_d;
            tx_par_q <= tx_par_d;  tx_stop_q <= tx_stop_d;  txd_q <= txd_d;  tx_cnt_q <= tx_cnt_d;
            rx_state_q <= rx_state_d;  rx_sh_q <= rx_sh_d;  rx_bit_q <= rx_bit_d;
            rx_par_q <= rx_par_d;
            rx_s1_q <= rx_s1_d;  rx_s2_q <= rx_s2_d;  rx_prev_q <= rx_prev_d;  rx_cnt_q <= rx_cnt_d;
        end
    end

    assign dout  = dout_q;
    assign txd   = txd_q;
    assign txrdy = txen_q & ~thr_full_q;
    assign rxrdy = rxrdy_q;

endmodule

// File: tb/tb_usart_lite.sv
// Directed bench for usart_lite at BAUD_DIV=4 (x16 => 64 clocks per bit).
module tb_usart_lite;

    localparam int unsigned BT = 64;

    logic       clk = 1'b0;
    logic       rst_n, io_c, io_d, wr, rd, rxd_drv, loop_en;
    logic [7:0] din, dout;
    logic       rxd, txd, txrdy, rxrdy;
    int unsigned cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    assign rxd = loop_en ? txd : rxd_drv;

    usart_lite #(.BAUD_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .io_c(io_c), .io_d(io_d), .wr(wr), .rd(rd),
        .din(din), .dout(dout), .rxd(rxd), .txd(txd), .txrdy(txrdy), .rxrdy(rxrdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cpu_write(input logic c, input logic [7:0] d);
        @(negedge clk);
        io_c = c;  io_d = !c;  wr = 1'b1;  din = d;
        @(negedge clk);
        wr = 1'b0;  io_c = 1'b0;  io_d = 1'b0;
    endtask

    task automatic cpu_read(input logic c, output logic [7:0] v);
        @(negedge clk);
        io_c = c;  io_d = !c;  rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;  io_c = 1'b0;  io_d = 1'b0;
        v = dout;
    endtask

    task automatic sample_txd(input int unsigned t, output logic v);
        while (cyc < t) @(negedge clk);
        v = txd;
    endtask

    task automatic wait_txd_fall(output int unsigned c0, output bit ok);
        ok = 1'b0;  c0 = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                c0 = cyc;  ok = 1'b1;
                break;
            end
        end
    endtask

    // v[k] = txd at the centre of bit k of the frame whose start was first seen at c0.
    task automatic capture(input int unsigned c0, input int first, input int last,
                           output logic [15:0] v);
        logic b;
        v = '0;
        for (int k = first; k <= last; k++) begin
            sample_txd(c0 + BT * k + BT / 2, b);
            v[k] = b;
        end
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic stop_v);
        rxd_drv = 1'b0;
        repeat (BT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = d[i];
            repeat (BT) @(negedge clk);
        end
        rxd_drv = stop_v;
        repeat (BT) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (100) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks += 4;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd got %b want 1", txd); end
        if (txrdy !== 1'b0) begin n_fail++; $display("FAIL reset_txrdy got %b want 0", txrdy); end
        if (rxrdy !== 1'b0) begin n_fail++; $display("FAIL reset_rxrdy got %b want 0", rxrdy); end
        if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want 00", dout); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_one_byte;
        int unsigned c0;  bit ok;  logic b;  logic [15:0] v;  logic [7:0] s;
        cpu_write(1'b1, 8'h4E);
        cpu_write(1'b1, 8'h05);
        n_checks++;
        if (txrdy !== 1'b1) begin n_fail++; $display("FAIL tx1_txrdy_en got %b want 1", txrdy); end
        cpu_write(1'b0, 8'h41);
        n_checks++;
        if (txrdy !== 1'b0) begin n_fail++; $display("FAIL tx1_txrdy_wr got %b want 0", txrdy); end
        wait_txd_fall(c0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL tx1_start got timeout want start bit"); end
        sample_txd(c0 + BT - 1, b);
        n_checks++;
        if (b !== 1'b0) begin n_fail++; $display("FAIL tx1_start_end got %b want 0", b); end
        sample_txd(c0 + BT, b);
        n_checks++;
        if (b !== 1'b1) begin n_fail++; $display("FAIL tx1_bit0_begin got %b want 1", b); end
        capture(c0, 1, 9, v);
        n_checks += 2;
        if (v[8:1] !== 8'h41) begin n_fail++; $display("FAIL tx1_data got %h want 41", v[8:1]); end
        if (v[9] !== 1'b1) begin n_fail++; $display("FAIL tx1_stop got %b want 1", v[9]); end
        sample_txd(c0 + 10 * BT + 20, b);
        cpu_read(1'b1, s);
        n_checks++;
        if (s !== 8'h05) begin n_fail++; $display("FAIL tx1_status got %h want 05", s); end
    endtask

    task automatic test_parity_loop;
        int unsigned c0;  bit ok;  bit got;  logic [15:0] v;  logic [7:0] s;
        cpu_write(1'b1, 8'h40);
        cpu_write(1'b1, 8'h7A);
        cpu_write(1'b1, 8'h05);
        loop_en = 1'b1;
        cpu_write(1'b0, 8'h55);
        wait_txd_fall(c0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL par_start got timeout want start bit"); end
        capture(c0, 0, 10, v);
        n_checks += 3;
        if (v[7:0] !== 8'hAA) begin n_fail++; $display("FAIL par_data got %h want aa", v[7:0]); end
        if (v[8] !== 1'b0) begin n_fail++; $display("FAIL par_bit got %b want 0", v[8]); end
        if (v[10:9] !== 2'b11) begin n_fail++; $display("FAIL par_stop_idle got %b want 11", v[10:9]); end
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (rxrdy === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL par_rxrdy got timeout want 1"); end
        cpu_read(1'b1, s);
        n_checks++;
        if (s !== 8'h07) begin n_fail++; $display("FAIL par_status got %h want 07", s); end
        cpu_read(1'b0, s);
        n_checks++;
        if (s !== 8'h55) begin n_fail++; $display("FAIL par_rhr got %h want 55", s); end
        n_checks++;
        if (rxrdy !== 1'b0) begin n_fail++; $display("FAIL par_rxrdy_clr got %b want 0", rxrdy); end
        loop_en = 1'b0;
    endtask

    task automatic test_rx_errors;
        logic [7:0] s;
        cpu_write(1'b1, 8'h40);
        cpu_write(1'b1, 8'h4E);
        cpu_write(1'b1, 8'h04);
        repeat (20) @(negedge clk);
        drive_rx(8'hA5, 1'b0);
        n_checks++;
        if (rxrdy !== 1'b1) begin n_fail++; $display("FAIL fe_rxrdy got %b want 1", rxrdy); end
        cpu_read(1'b1, s);
        n_checks++;
        if (s !== 8'h22) begin n_fail++; $display("FAIL fe_status got %h want 22", s); end
        drive_rx(8'h3C, 1'b1);
        cpu_read(1'b1, s);
        n_checks++;
        if (s !== 8'h32) begin n_fail++; $display("FAIL oe_status got %h want 32", s); end
        cpu_write(1'b1, 8'h15);
        cpu_read(1'b1, s);
        n_checks++;
        if (s !== 8'h07) begin n_fail++; $display("FAIL errclr_status got %h want 07", s); end
        cpu_read(1'b0, s);
        n_checks++;
        if (s !== 8'h3C) begin n_fail++; $display("FAIL oe_rhr got %h want 3c", s); end
    endtask

    task automatic test_glitch;
        logic [7:0] s;
        rxd_drv = 1'b0;
        repeat (3) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (300) @(negedge clk);
        cpu_read(1'b1, s);
        n_checks++;
        if (s !== 8'h05) begin n_fail++; $display("FAIL glitch_status got %h want 05", s); end
    endtask

    task automatic test_internal_reset;
        int unsigned c0;  bit ok;  logic b;  logic [7:0] s;
        cpu_write(1'b0, 8'h00);
        wait_txd_fall(c0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL ir_start got timeout want start bit"); end
        sample_txd(c0 + 2 * BT + BT / 2, b);
        n_checks++;
        if (b !== 1'b0) begin n_fail++; $display("FAIL ir_data_bit got %b want 0", b); end
        cpu_write(1'b1, 8'h40);
        n_checks += 2;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL ir_txd got %b want 1", txd); end
        if (txrdy !== 1'b0) begin n_fail++; $display("FAIL ir_txrdy got %b want 0", txrdy); end
        cpu_read(1'b1, s);
        n_checks++;
        if (s !== 8'h00) begin n_fail++; $display("FAIL ir_status got %h want 00", s); end
        cpu_write(1'b1, 8'h4E);
        cpu_read(1'b1, s);
        n_checks++;
        if (s !== 8'h00) begin n_fail++; $display("FAIL ir_mode_status got %h want 00", s); end
        cpu_write(1'b1, 8'h01);
        cpu_read(1'b1, s);
        n_checks += 2;
        if (s !== 8'h05) begin n_fail++; $display("FAIL ir_txen_status got %h want 05", s); end
        if (txrdy !== 1'b1) begin n_fail++; $display("FAIL ir_txen_txrdy got %b want 1", txrdy); end
    endtask

    task automatic test_back_to_back;
        int unsigned c0;  bit ok;  logic b;  logic [15:0] v;
        cpu_write(1'b0, 8'h31);
        wait_txd_fall(c0, ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL b2b_start got timeout want start bit"); end
        if (txrdy !== 1'b1) begin n_fail++; $display("FAIL b2b_txrdy got %b want 1", txrdy); end
        cpu_write(1'b0, 8'h32);
        capture(c0, 1, 9, v);
        n_checks++;
        if (v[9:1] !== 9'h131) begin n_fail++; $display("FAIL b2b_frame1 got %h want 131", v[9:1]); end
        sample_txd(c0 + 10 * BT - 1, b);
        n_checks++;
        if (b !== 1'b1) begin n_fail++; $display("FAIL b2b_stop_end got %b want 1", b); end
        sample_txd(c0 + 10 * BT, b);
        n_checks++;
        if (b !== 1'b0) begin n_fail++; $display("FAIL b2b_no_gap got %b want 0", b); end
        capture(c0 + 10 * BT, 1, 9, v);
        n_checks++;
        if (v[9:1] !== 9'h132) begin n_fail++; $display("FAIL b2b_frame2 got %h want 132", v[9:1]); end
    endtask

    initial begin
        rst_n = 1'b0;  io_c = 1'b0;  io_d = 1'b0;  wr = 1'b0;  rd = 1'b0;
        din = 8'h00;  rxd_drv = 1'b1;  loop_en = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_one_byte();
        test_parity_loop();
        test_rx_errors();
        test_glitch();
        test_internal_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
